// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port unified memory between the instruction-fetch port and the
// data (MEM-stage) port. Each access is sequenced as a valid/ready transaction. Store
// data is steered onto byte lanes and load data is extended. Misaligned or illegal
// accesses and memory timeouts are reported.
module riscv_mem_arbiter #(
    parameter int unsigned DATA_PRIO      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    // The counter only has to reach TIMEOUT_CYCLES-1; the limit check happens in that cycle.
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrFunct3   = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIfAcc, StDAcc} state_e;

    state_e        state_q;
    logic          last_d_q;   // 1 when the most recent grant went to the data port
    logic [2:0]    f3_q;
    logic [1:0]    addr_lo_q;
    logic [TW-1:0] tcnt_q;

    logic          grant_if, grant_d;
    logic [1:0]    d_fault, if_fault;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic          timeout_hit;

    // Pick a winner among eligible requesters; a port is not eligible while its ready pulses.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (d_req && !d_ready && if_req && !if_ready) begin
            if (DATA_PRIO != 0 || !last_d_q) grant_d = 1'b1;
            else                             grant_if = 1'b1;
        end else begin
            grant_d  = d_req && !d_ready;
            grant_if = if_req && !if_ready;
        end
    end

    // Classify the requests: illegal width takes precedence over misalignment.
    always_comb begin
        d_fault = 2'b00;
        if (d_funct3 == 3'b011 || d_funct3[2:1] == 2'b11) begin
            d_fault = ErrFunct3;
        end else if (d_funct3[1:0] == 2'b01 && d_addr[0]) begin
            d_fault = ErrMisalign;
        end else if (d_funct3[1:0] == 2'b10 && d_addr[1:0] != 2'b00) begin
            d_fault = ErrMisalign;
        end
        if_fault = (if_addr[1:0] != 2'b00) ? ErrMisalign : 2'b00;
    end

    // Byte enables and lane-replicated store data; loads read the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = d_wdata;
        if (d_we) begin
            case (d_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << d_addr[1:0];
                    st_wdata = {4{d_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << d_addr[1:0];
                    st_wdata = {2{d_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Select and extend the loaded byte/half using the latched funct3 and offset.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo_q)
            2'b00:   b = mem_rdata[7:0];
            2'b01:   b = mem_rdata[15:8];
            2'b10:   b = mem_rdata[23:16];
            default: b = mem_rdata[31:24];
        endcase
        h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{b[7]}}, b};
            3'b001:  ld_data = {{16{h[15]}}, h};
            3'b100:  ld_data = {24'h0, b};
            3'b101:  ld_data = {16'h0, h};
            default: ld_data = mem_rdata;
        endcase
    end

    // Limit check; mem_ready in the same cycle still takes precedence in the FSM.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TLAST);
    end

    // Arbitration/access FSM with all port outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            last_d_q  <= 1'b0;
            f3_q      <= 3'b000;
            addr_lo_q <= 2'b00;
            tcnt_q    <= '0;
            if_rdata  <= 32'h0;
            if_ready  <= 1'b0;
            d_rdata   <= 32'h0;
            d_ready   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        last_d_q <= 1'b1;
                        if (d_fault != 2'b00) begin
                            d_ready  <= 1'b1;
                            err      <= 1'b1;
                            err_code <= d_fault;
                            d_rdata  <= 32'h0;
                        end else begin
                            state_q   <= StDAcc;
                            mem_valid <= 1'b1;
                            mem_we    <= d_we;
                            mem_be    <= st_be;
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_wdata <= st_wdata;
                            f3_q      <= d_funct3;
                            addr_lo_q <= d_addr[1:0];
                            tcnt_q    <= '0;
                        end
                    end else if (grant_if) begin
                        last_d_q <= 1'b0;
                        if (if_fault != 2'b00) begin
                            if_ready <= 1'b1;
                            err      <= 1'b1;
                            err_code <= if_fault;
                            if_rdata <= 32'h0;
                        end else begin
                            state_q   <= StIfAcc;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_be    <= 4'b1111;
                            mem_addr  <= {if_addr[31:2], 2'b00};
                            mem_wdata <= 32'h0;
                            tcnt_q    <= '0;
                        end
                    end
                end
                StIfAcc, StDAcc: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state_q   <= StIdle;
                        if (state_q == StIfAcc) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_we ? 32'h0 : ld_data;
                        end
                    end else if (timeout_hit) begin
                        mem_valid <= 1'b0;
                        state_q   <= StIdle;
                        err       <= 1'b1;
                        err_code  <= ErrTimeout;
                        if (state_q == StIfAcc) begin
                            if_ready <= 1'b1;
                            if_rdata <= 32'h0;
                        end else begin
                            d_ready <= 1'b1;
                            d_rdata <= 32'h0;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule
